writeback_arbiter: RTL and testbench

Merges the single-cycle ALU result stream and the variable-latency load-response stream into the register file's single write port. Load responses are buffered in a small FIFO, a pending-load scoreboard is kept for the issue stage's hazard check, and the write is presented to the register file as registered `write_port`/`write_data`/`write_enable` signals. The block sits directly upstream of the register file.

---
 rtl/writeback_arbiter_if.sv | 53 +++++
 rtl/writeback_arbiter.sv | 171 +++++++++++++++++
 tb/tb_writeback_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
//
// Bundles every handshake and bus signal of the writeback arbiter.
// The clock and reset stay plain ports on the arbiter.
//
// Signal groups:
//   ALU result stream  : alu_valid, alu_ready, alu_rd, alu_data
//   load response      : load_valid, load_ready, load_rd, load_data
//   load issue         : issue_valid, issue_rd
//   scoreboard         : pending
//   register-file port : write_port, write_data, write_enable
//
// Modports:
//   slave  - the arbiter's view of the bundle
//   master - the surrounding pipeline's view of the bundle
interface writeback_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            load_valid;
    logic            load_ready;
    logic [4:0]      load_rd;
    logic [XLEN-1:0] load_data;

    logic            issue_valid;
    logic [4:0]      issue_rd;

    logic [31:0]     pending;

    logic [4:0]      write_port;
    logic [XLEN-1:0] write_data;
    logic            write_enable;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  load_valid, load_rd, load_data,
        input  issue_valid, issue_rd,
        output alu_ready, load_ready, pending,
        output write_port, write_data, write_enable
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output load_valid, load_rd, load_data,
        output issue_valid, issue_rd,
        input  alu_ready, load_ready, pending,
        input  write_port, write_data, write_enable
    );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Merges the single-cycle ALU result stream and the variable-latency load
// response stream into the single register-file write port. Load responses
// are buffered in a small FIFO. A pending-load scoreboard is kept for the
// issue stage's hazard check. The write is presented as registered outputs.
//
// Parameters:
//   XLEN  - data width
//   DEPTH - load FIFO entries (power of 2, at least 2)
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - writeback_arbiter_if.slave (ALU and load streams, issue,
//           pending scoreboard, register-file write port)
//
// Optional feature:
//   WB_LOAD_BYPASS_EN - Suppose the FIFO is empty and no ALU result is
//                       offered. A load response then goes straight into the
//                       output register and skips the FIFO.
module writeback_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    writeback_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    // The pointers carry one extra wrap bit. The FIFO is full when only the
    // wrap bits differ.
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [4:0]      fifo_rd_d   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_data_d [DEPTH];

    logic            write_enable_q, write_enable_d;
    logic [4:0]      write_port_q, write_port_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [31:0]     pending_q, pending_d;

    logic            full;
    logic            empty;
    logic            sel_alu;
    logic            sel_fifo;
    logic            sel_bypass;
    logic            load_win;
    logic            has_winner;
    logic            enq;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic [AW-1:0]   head_idx;
    logic [AW-1:0]   tail_idx;

    assign head_idx = rd_ptr_q[AW-1:0];
    assign tail_idx = wr_ptr_q[AW-1:0];
    assign empty    = (rd_ptr_q == wr_ptr_q);
    assign full     = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
                      (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);

    // The slot freed by a dequeue only becomes usable after the edge, so
    // load_ready is based on the current fullness alone. The ALU is refused
    // only while the full FIFO forces a drain.
    assign bus.load_ready = !full;
    assign bus.alu_ready  = !full;

    // Pick the winner. A full FIFO outranks the ALU, so loads cannot starve
    // under continuous ALU traffic.
    always_comb begin
        sel_alu    = 1'b0;
        sel_fifo   = 1'b0;
        sel_bypass = 1'b0;
        if (full) begin
            sel_fifo = 1'b1;
        end else if (bus.alu_valid) begin
            sel_alu = 1'b1;
        end else if (!empty) begin
            sel_fifo = 1'b1;
        end
`ifdef WB_LOAD_BYPASS_EN
        else if (bus.load_valid) begin
            sel_bypass = 1'b1;
        end
`endif
    end

    assign load_win   = sel_fifo || sel_bypass;
    assign has_winner = sel_alu || load_win;
    // A bypassed load is consumed directly and never enters the FIFO.
    assign enq        = bus.load_valid && !full && !sel_bypass;

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        if (sel_alu) begin
            win_rd   = bus.alu_rd;
            win_data = bus.alu_data;
        end else if (sel_fifo) begin
            win_rd   = fifo_rd_q[head_idx];
            win_data = fifo_data_q[head_idx];
        end else if (sel_bypass) begin
            win_rd   = bus.load_rd;
            win_data = bus.load_data;
        end
    end

    // FIFO next state: write at the tail on enqueue, advance the head
    // whenever the FIFO supplies the winner.
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, enq};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, sel_fifo};
        if (enq) begin
            fifo_rd_d[tail_idx]   = bus.load_rd;
            fifo_data_d[tail_idx] = bus.load_data;
        end
    end

    // Output register: a winner with rd 0 is consumed but not written.
    // When there is no winner, the port and data hold their values.
    always_comb begin
        write_enable_d = has_winner && (win_rd != 5'd0);
        write_port_d   = has_winner ? win_rd   : write_port_q;
        write_data_d   = has_winner ? win_data : write_data_q;
    end

    // Scoreboard: the clear is applied first, so a same-cycle set to the
    // same register wins.
    always_comb begin
        pending_d = pending_q;
        if (load_win) begin
            pending_d[win_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            fifo_rd_q      <= '{default: '0};
            fifo_data_q    <= '{default: '0};
            write_enable_q <= 1'b0;
            write_port_q   <= '0;
            write_data_q   <= '0;
            pending_q      <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            fifo_rd_q      <= fifo_rd_d;
            fifo_data_q    <= fifo_data_d;
            write_enable_q <= write_enable_d;
            write_port_q   <= write_port_d;
            write_data_q   <= write_data_d;
            pending_q      <= pending_d;
        end
    end

    assign bus.write_enable = write_enable_q;
    assign bus.write_port   = write_port_q;
    assign bus.write_data   = write_data_q;
    assign bus.pending      = pending_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//
// Directed bench for writeback_arbiter (XLEN=32, DEPTH=4).
// A table of per-cycle vectors covers these cases:
//   - ALU writes
//   - rd 0 suppression
//   - the starvation guard with in-order load draining
//   - scoreboard set/clear and the set-wins collision
// Hand-written sequences cover these cases:
//   - load latency
//   - the rd 9 collision
//   - asynchronous reset with a partly filled FIFO
module tb_writeback_arbiter;
    logic clock;
    logic reset;

    writeback_arbiter_if #(.XLEN(32)) bus ();

    writeback_arbiter #(
        .XLEN  (32),
        .DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        load_valid;
        logic [4:0]  load_rd;
        logic [31:0] load_data;
        logic        issue_valid;
        logic [4:0]  issue_rd;
        logic        exp_alu_ready;
        logic        exp_load_ready;
        logic        exp_we;
        logic [4:0]  exp_port;
        logic [31:0] exp_data;
        logic [31:0] exp_pending;
    } vec_t;

    vec_t vecs[$];
    int   tests_run;
    int   tests_failed;

    function automatic vec_t mkVec(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic iv, input logic [4:0] ird,
        input logic ear, input logic elr,
        input logic ewe, input logic [4:0] ep, input logic [31:0] ed,
        input logic [31:0] epd);
        vec_t v;
        v.alu_valid      = av;
        v.alu_rd         = ard;
        v.alu_data       = ad;
        v.load_valid     = lv;
        v.load_rd        = lrd;
        v.load_data      = ld;
        v.issue_valid    = iv;
        v.issue_rd       = ird;
        v.exp_alu_ready  = ear;
        v.exp_load_ready = elr;
        v.exp_we         = ewe;
        v.exp_port       = ep;
        v.exp_data       = ed;
        v.exp_pending    = epd;
        return v;
    endfunction

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the inputs of one cycle.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                 input logic iv, input logic [4:0] ird);
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_data    = ad;
        bus.load_valid  = lv;
        bus.load_rd     = lrd;
        bus.load_data   = ld;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic we, input logic [4:0] port,
                             input logic [31:0] data, input logic [31:0] pend);
        checkOutput({tag, "_we"}, {31'b0, bus.write_enable}, {31'b0, we});
        if (we) begin
            checkOutput({tag, "_port"}, {27'b0, bus.write_port}, {27'b0, port});
            checkOutput({tag, "_data"}, bus.write_data, data);
        end
        checkOutput({tag, "_pending"}, bus.pending, pend);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        idleInputs();

        // Per-cycle vectors. The readies are sampled before the edge. The
        // registered outputs are sampled just after the edge.
        vecs.push_back(mkVec(1,5'd5,32'hDEADBEEF, 0,5'd0,32'h0,  0,5'd0,  1,1, 1,5'd5,32'hDEADBEEF, 32'h0));
        vecs.push_back(mkVec(0,5'd0,32'h0,        0,5'd0,32'h0,  0,5'd0,  1,1, 0,5'd5,32'hDEADBEEF, 32'h0));
        vecs.push_back(mkVec(1,5'd0,32'hFFFFFFFF, 0,5'd0,32'h0,  0,5'd0,  1,1, 0,5'd0,32'hFFFFFFFF, 32'h0));
        vecs.push_back(mkVec(0,5'd0,32'h0,        0,5'd0,32'h0,  0,5'd0,  1,1, 0,5'd0,32'hFFFFFFFF, 32'h0));
        vecs.push_back(mkVec(1,5'd1,32'h101,      0,5'd0,32'h0,  1,5'd10, 1,1, 1,5'd1,32'h101,      32'h0400));
        vecs.push_back(mkVec(1,5'd2,32'h102,      1,5'd10,32'hA0,1,5'd11, 1,1, 1,5'd2,32'h102,      32'h0C00));
        vecs.push_back(mkVec(1,5'd3,32'h103,      1,5'd11,32'hA1,1,5'd12, 1,1, 1,5'd3,32'h103,      32'h1C00));
        vecs.push_back(mkVec(1,5'd4,32'h104,      1,5'd12,32'hA2,1,5'd13, 1,1, 1,5'd4,32'h104,      32'h3C00));
        vecs.push_back(mkVec(1,5'd5,32'h105,      1,5'd13,32'hA3,0,5'd0,  1,1, 1,5'd5,32'h105,      32'h3C00));
        vecs.push_back(mkVec(1,5'd6,32'h106,      1,5'd14,32'hA4,0,5'd0,  0,0, 1,5'd10,32'hA0,      32'h3800));
        vecs.push_back(mkVec(1,5'd6,32'h106,      1,5'd14,32'hA4,0,5'd0,  1,1, 1,5'd6,32'h106,      32'h3800));
        vecs.push_back(mkVec(1,5'd7,32'h107,      0,5'd0,32'h0,  0,5'd0,  0,0, 1,5'd11,32'hA1,      32'h3000));
        vecs.push_back(mkVec(1,5'd7,32'h107,      0,5'd0,32'h0,  0,5'd0,  1,1, 1,5'd7,32'h107,      32'h3000));
        vecs.push_back(mkVec(0,5'd0,32'h0,        0,5'd0,32'h0,  0,5'd0,  1,1, 1,5'd12,32'hA2,      32'h2000));
        vecs.push_back(mkVec(0,5'd0,32'h0,        0,5'd0,32'h0,  0,5'd0,  1,1, 1,5'd13,32'hA3,      32'h0000));
        vecs.push_back(mkVec(0,5'd0,32'h0,        0,5'd0,32'h0,  1,5'd14, 1,1, 1,5'd14,32'hA4,      32'h4000));
        vecs.push_back(mkVec(0,5'd0,32'h0,        0,5'd0,32'h0,  1,5'd0,  1,1, 0,5'd14,32'hA4,      32'h4000));

        // Check the reset state while reset is still asserted.
        tick();
        checkOutput("reset_we", {31'b0, bus.write_enable}, 32'h0);
        checkOutput("reset_port", {27'b0, bus.write_port}, 32'h0);
        checkOutput("reset_data", bus.write_data, 32'h0);
        checkOutput("reset_pending", bus.pending, 32'h0);
        checkOutput("reset_load_ready", {31'b0, bus.load_ready}, 32'h1);
        checkOutput("reset_alu_ready", {31'b0, bus.alu_ready}, 32'h1);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].alu_valid, vecs[i].alu_rd, vecs[i].alu_data,
                          vecs[i].load_valid, vecs[i].load_rd, vecs[i].load_data,
                          vecs[i].issue_valid, vecs[i].issue_rd);
            #1;
            checkOutput($sformatf("vec%0d_alu_ready", i), {31'b0, bus.alu_ready},
                        {31'b0, vecs[i].exp_alu_ready});
            checkOutput($sformatf("vec%0d_load_ready", i), {31'b0, bus.load_ready},
                        {31'b0, vecs[i].exp_load_ready});
            tick();
            checkOutput($sformatf("vec%0d_we", i), {31'b0, bus.write_enable},
                        {31'b0, vecs[i].exp_we});
            checkOutput($sformatf("vec%0d_port", i), {27'b0, bus.write_port},
                        {27'b0, vecs[i].exp_port});
            checkOutput($sformatf("vec%0d_data", i), bus.write_data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_pending", i), bus.pending, vecs[i].exp_pending);
        end

        // Load latency: issue to rd 7, then send the response three cycles later.
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7);
        tick();
        checkRegs("lat_issue", 1'b0, 5'd0, 32'h0, 32'h4080);
        idleInputs();
        tick();
        checkRegs("lat_wait1", 1'b0, 5'd0, 32'h0, 32'h4080);
        tick();
        checkRegs("lat_wait2", 1'b0, 5'd0, 32'h0, 32'h4080);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd7, 32'h1234, 0, 5'd0);
        #1;
        checkOutput("lat_load_ready", {31'b0, bus.load_ready}, 32'h1);
        tick();
        idleInputs();
`ifdef WB_LOAD_BYPASS_EN
        checkRegs("lat_n1", 1'b1, 5'd7, 32'h1234, 32'h4000);
`else
        checkRegs("lat_n1", 1'b0, 5'd0, 32'h0, 32'h4080);
        tick();
        checkRegs("lat_n2", 1'b1, 5'd7, 32'h1234, 32'h4000);
`endif
        tick();
        checkRegs("lat_after", 1'b0, 5'd0, 32'h0, 32'h4000);

        // Issue to rd 9 in the same cycle as a load to rd 9 commits.
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9);
        tick();
        checkRegs("col_issue", 1'b0, 5'd0, 32'h0, 32'h4200);
        applyStimulus(1, 5'd1, 32'h55, 1, 5'd9, 32'h99, 0, 5'd0);
        tick();
        checkRegs("col_alu", 1'b1, 5'd1, 32'h55, 32'h4200);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9);
        tick();
        checkRegs("col_commit", 1'b1, 5'd9, 32'h99, 32'h4200);

        // Clear everything, then build pending=0x280 with three queued loads.
        idleInputs();
        reset = 1'b1;
        #1;
        checkOutput("clr_pending", bus.pending, 32'h0);
        #2;
        reset = 1'b0;
        applyStimulus(1, 5'd1, 32'h1, 0, 5'd0, 32'h0, 1, 5'd7);
        tick();
        applyStimulus(1, 5'd2, 32'h2, 1, 5'd20, 32'hA20, 1, 5'd9);
        tick();
        applyStimulus(1, 5'd3, 32'h3, 1, 5'd21, 32'hA21, 0, 5'd0);
        tick();
        applyStimulus(1, 5'd4, 32'h4, 1, 5'd22, 32'hA22, 0, 5'd0);
        tick();
        checkRegs("rst_pre", 1'b1, 5'd4, 32'h4, 32'h0280);
        idleInputs();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_we", {31'b0, bus.write_enable}, 32'h0);
        checkOutput("rst_async_port", {27'b0, bus.write_port}, 32'h0);
        checkOutput("rst_async_data", bus.write_data, 32'h0);
        checkOutput("rst_async_pending", bus.pending, 32'h0);
        checkOutput("rst_async_load_ready", {31'b0, bus.load_ready}, 32'h1);
        checkOutput("rst_async_alu_ready", {31'b0, bus.alu_ready}, 32'h1);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("rst_stale%0d_we", k), {31'b0, bus.write_enable}, 32'h0);
            checkOutput($sformatf("rst_stale%0d_pending", k), bus.pending, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
